// File: rtl/regbank_param.sv
// Parametrised CSR bank: NUM_REGS registers of DATA_W bits at BASE_ADDR + i*ADDR_STRIDE.
// Per-register access mode (RW, RO, W1C, WO-pulse), unmapped-address error flags and a
// registered interrupt summary over all W1C bits. Read and write paths are independent.
module regbank_param #(
  parameter int                         DATA_W      = 32,
  parameter int                         ADDR_W      = 16,
  parameter int                         NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0]          BASE_ADDR   = '0,
  parameter int                         ADDR_STRIDE = 4,
  parameter logic [2*NUM_REGS-1:0]      REG_MODE    = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL     = '0
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W/8-1:0]          be,
  input  logic [DATA_W-1:0]            wdata,
  output logic                         wr_ack,
  output logic                         wr_err,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rd_rdy,
  output logic                         rd_err,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_val,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
  output logic                         irq
);

  localparam int              BE_W   = DATA_W / 8;
  localparam int              SHIFT  = $clog2(ADDR_STRIDE);
  localparam logic [ADDR_W-1:0] S_MASK = ADDR_W'(ADDR_STRIDE - 1);
  localparam logic [ADDR_W-1:0] N_REGS = ADDR_W'(NUM_REGS);
  localparam logic [1:0] M_RW  = 2'd0;
  localparam logic [1:0] M_RO  = 2'd1;
  localparam logic [1:0] M_W1C = 2'd2;
  localparam logic [1:0] M_WO  = 2'd3;

  logic [ADDR_W-1:0]   wr_off, rd_off, wr_idx, rd_idx;
  logic                wr_hit, rd_hit, wr_ro;
  logic [DATA_W-1:0]   bmask, wmasked, rd_val;
  logic [NUM_REGS-1:0] wr_sel;
  logic                w1c_any;

  // Address decode: aligned offset from BASE_ADDR with an in-range index is a hit
  always_comb begin
    wr_off = wr_addr - BASE_ADDR;
    rd_off = rd_addr - BASE_ADDR;
    wr_idx = wr_off >> SHIFT;
    rd_idx = rd_off >> SHIFT;
    wr_hit = (wr_addr >= BASE_ADDR) && ((wr_off & S_MASK) == '0) && (wr_idx < N_REGS);
    rd_hit = (rd_addr >= BASE_ADDR) && ((rd_off & S_MASK) == '0) && (rd_idx < N_REGS);
  end

  // Byte-enable expansion and per-register write select
  always_comb begin
    bmask = '0;
    for (int k = 0; k < BE_W; k++) bmask[8*k +: 8] = {8{be[k]}};
    wmasked = wdata & bmask;
    wr_sel  = '0;
    wr_ro   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && wr_hit && (wr_idx == ADDR_W'(i))) begin
        wr_sel[i] = 1'b1;
        if (REG_MODE[2*i +: 2] == M_RO) wr_ro = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [1:0] MODE = REG_MODE[2*i +: 2];
    if (MODE == M_RO) begin : g_ro
      // RO registers expose the live hardware value; there is no storage
      assign reg_q[i*DATA_W +: DATA_W] = hw_val[i*DATA_W +: DATA_W];
    end else begin : g_st
      logic [DATA_W-1:0] q;
      // Register update by mode; W1C set strobes take priority over a same-cycle clear
      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          q <= (MODE == M_WO) ? '0 : RST_VAL[i*DATA_W +: DATA_W];
        end else begin
          case (MODE)
            M_RW:    if (wr_sel[i]) q <= (q & ~bmask) | wmasked;
            M_W1C:   q <= (q & ~(wr_sel[i] ? wmasked : '0)) | hw_set[i*DATA_W +: DATA_W];
            default: q <= wr_sel[i] ? wmasked : '0;
          endcase
        end
      end
      assign reg_q[i*DATA_W +: DATA_W] = q;
    end
  end

  // hw_set only matters for W1C slots; the reduction keeps the full port referenced
  logic unused_hw_set;
  assign unused_hw_set = ^hw_set;

  // Read mux and W1C summary; WO registers always read back as zero
  always_comb begin
    rd_val  = '0;
    w1c_any = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((rd_idx == ADDR_W'(i)) && (REG_MODE[2*i +: 2] != M_WO))
        rd_val = reg_q[i*DATA_W +: DATA_W];
      if (REG_MODE[2*i +: 2] == M_W1C)
        w1c_any = w1c_any | (|reg_q[i*DATA_W +: DATA_W]);
    end
  end

  // Write response: one-cycle ack, error on unmapped or read-only target
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_en;
      wr_err <= wr_en && (!wr_hit || wr_ro);
    end
  end

  // Read response: data captured at the rd_en edge, zero whenever rd_rdy is low
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_rdy <= 1'b0;
      rd_err <= 1'b0;
      rdata  <= '0;
    end else begin
      rd_rdy <= rd_en;
      rd_err <= rd_en && !rd_hit;
      rdata  <= (rd_en && rd_hit) ? rd_val : '0;
    end
  end

  // Interrupt summary follows the stored W1C state one cycle later
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) irq <= 1'b0;
    else       irq <= w1c_any;
  end

endmodule

// File: tb/tb_regbank_param.sv
// Bench for regbank_param: reg0 RW (reset A5A5_0001), reg1 RO, reg2 W1C, reg3 WO, reg4..7 RW.
module tb_regbank_param;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NR = 8;
  localparam logic [2*NR-1:0]  MODES = 16'h00E4;
  localparam logic [NR*DW-1:0] RSTV  = {224'h0, 32'hA5A5_0001};

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [3:0]     be = '0;
  logic [DW-1:0]  wdata = '0;
  logic           wr_ack, wr_err;
  logic           rd_en = 1'b0;
  logic [AW-1:0]  rd_addr = '0;
  logic [DW-1:0]  rdata;
  logic           rd_rdy, rd_err;
  logic [NR*DW-1:0] reg_q;
  logic [NR*DW-1:0] hw_val = '0;
  logic [NR*DW-1:0] hw_set = '0;
  logic           irq;

  regbank_param #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .BASE_ADDR(16'h0000),
    .ADDR_STRIDE(4), .REG_MODE(MODES), .RST_VAL(RSTV)
  ) dut (
    .clk(clk), .rstb(rstb),
    .wr_en(wr_en), .wr_addr(wr_addr), .be(be), .wdata(wdata),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata), .rd_rdy(rd_rdy), .rd_err(rd_err),
    .reg_q(reg_q), .hw_val(hw_val), .hw_set(hw_set), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_werr;
    logic        rd;
    logic [15:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_rerr;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] rq[$];
  logic        wq[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after a rising edge and queue its expected responses
  task automatic drive(input vec_t v);
    @(posedge clk); #1;
    wr_en = v.wr; wr_addr = v.waddr; be = v.be; wdata = v.wdata;
    rd_en = v.rd; rd_addr = v.raddr;
    if (v.wr) wq.push_back(v.exp_werr);
    if (v.rd) rq.push_back({v.exp_rerr, v.exp_rdata});
  endtask

  task automatic idle();
    vec_t v;
    v = '{0, 16'h0, 4'h0, 32'h0, 0, 0, 16'h0, 32'h0, 0};
    drive(v);
  endtask

  // Scoreboard: responses popped and compared mid-cycle
  always @(negedge clk) begin
    logic [32:0] e;
    if (rd_rdy) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_rdy=1 rdata=%h with nothing pending", rdata);
      end else begin
        e = rq.pop_front();
        if ({rd_err, rdata} !== e) begin
          errors++;
          $display("FAIL read: got err=%b data=%h expected err=%b data=%h",
                   rd_err, rdata, e[32], e[31:0]);
        end
      end
    end else begin
      checks++;
      if (rdata !== '0 || rd_err !== 1'b0) begin
        errors++;
        $display("FAIL rd_idle: got err=%b data=%h expected 0", rd_err, rdata);
      end
    end
    if (wr_ack) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: wr_ack=1 with nothing pending");
      end else if (wr_err !== wq.pop_front()) begin
        errors++;
        $display("FAIL write: wr_err=%b not as expected", wr_err);
      end
    end
  end

  initial begin
    hw_val[63:32] = 32'hCAFE_BEEF;

    //           wr waddr    be     wdata         werr rd raddr    rdata         rerr
    vecs.push_back('{0, 16'h0000, 4'h0, 32'h0,        0, 1, 16'h0000, 32'hA5A5_0001, 0});
    vecs.push_back('{1, 16'h0000, 4'hF, 32'hFFFF_FFFF, 0, 0, 16'h0000, 32'h0,        0});
    vecs.push_back('{1, 16'h0000, 4'h5, 32'h1122_3344, 0, 0, 16'h0000, 32'h0,        0});
    vecs.push_back('{0, 16'h0000, 4'h0, 32'h0,        0, 1, 16'h0000, 32'hFF22_FF44, 0});
    vecs.push_back('{0, 16'h0000, 4'h0, 32'h0,        0, 1, 16'h0004, 32'hCAFE_BEEF, 0});
    vecs.push_back('{1, 16'h0004, 4'hF, 32'h0000_1234, 1, 0, 16'h0000, 32'h0,        0});
    vecs.push_back('{1, 16'h0100, 4'hF, 32'hDEAD_BEEF, 1, 1, 16'h0002, 32'h0,        1});
    vecs.push_back('{0, 16'h0000, 4'h0, 32'h0,        0, 1, 16'h0000, 32'hFF22_FF44, 0});
    vecs.push_back('{0, 16'h0000, 4'h0, 32'h0,        0, 1, 16'h001C, 32'h0,        0});
    vecs.push_back('{1, 16'h0020, 4'hF, 32'h1,        1, 1, 16'h0020, 32'h0,        1});
    vecs.push_back('{1, 16'h0001, 4'hF, 32'h1,        1, 0, 16'h0000, 32'h0,        0});
    vecs.push_back('{1, 16'h0000, 4'h0, 32'hFFFF_FFFF, 0, 0, 16'h0000, 32'h0,        0});
    vecs.push_back('{0, 16'h0000, 4'h0, 32'h0,        0, 1, 16'h0000, 32'hFF22_FF44, 0});
    vecs.push_back('{1, 16'h0000, 4'hF, 32'h0,        0, 0, 16'h0000, 32'h0,        0});
    vecs.push_back('{1, 16'h0000, 4'hF, 32'h5,        0, 1, 16'h0000, 32'h0,        0});
    vecs.push_back('{0, 16'h0000, 4'h0, 32'h0,        0, 1, 16'h0000, 32'h5,        0});
    vecs.push_back('{0, 16'h0000, 4'h0, 32'h0,        0, 1, 16'h000C, 32'h0,        0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_rdy", {31'h0, rd_rdy}, 32'h0);
    chk("reset_wr_ack", {31'h0, wr_ack}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chk("reset_wo", reg_q[127:96], 32'h0);
    rstb = 1'b1;

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
    idle();
    chk("rw_reg_q", reg_q[31:0], 32'h5);

    // W1C: set strobe, irq lag, clear by write, then set-wins collision
    @(posedge clk); #1;
    hw_set[67] = 1'b1;
    @(posedge clk); #1;
    hw_set[67] = 1'b0;
    chk("w1c_set", reg_q[95:64], 32'h8);
    chk("irq_lag", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    chk("irq_set", {31'h0, irq}, 32'h1);
    drive('{1, 16'h0008, 4'hF, 32'h8, 0, 0, 16'h0, 32'h0, 0});
    drive('{0, 16'h0000, 4'h0, 32'h0, 0, 1, 16'h0008, 32'h0, 0});
    chk("w1c_clr", reg_q[95:64], 32'h0);
    idle();
    chk("irq_clr", {31'h0, irq}, 32'h0);
    drive('{1, 16'h0008, 4'hF, 32'h8, 0, 0, 16'h0, 32'h0, 0});
    hw_set[67] = 1'b1;
    drive('{0, 16'h0000, 4'h0, 32'h0, 0, 1, 16'h0008, 32'h8, 0});
    hw_set[67] = 1'b0;
    idle();
    idle();
    chk("irq_set_wins", {31'h0, irq}, 32'h1);

    // WO: back-to-back pulses, each exactly one cycle, byte-masked
    drive('{1, 16'h000C, 4'hF, 32'h0000_00FF, 0, 0, 16'h0, 32'h0, 0});
    drive('{1, 16'h000C, 4'h2, 32'h1234_AB56, 0, 0, 16'h0, 32'h0, 0});
    chk("wo_pulse1", reg_q[127:96], 32'h0000_00FF);
    drive('{0, 16'h0000, 4'h0, 32'h0, 0, 1, 16'h000C, 32'h0, 0});
    chk("wo_pulse2", reg_q[127:96], 32'h0000_AB00);
    idle();
    chk("wo_done", reg_q[127:96], 32'h0);

    // Reset while a read is in flight: the response is dropped
    @(posedge clk); #1;
    rd_en = 1'b1; rd_addr = 16'h0000;
    #2 rstb = 1'b0;
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk("rst_rd_rdy", {31'h0, rd_rdy}, 32'h0);
    @(posedge clk); #1;
    chk("rst_rd_rdy2", {31'h0, rd_rdy}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rstb = 1'b1;
    drive('{0, 16'h0000, 4'h0, 32'h0, 0, 1, 16'h0000, 32'hA5A5_0001, 0});
    drive('{0, 16'h0000, 4'h0, 32'h0, 0, 1, 16'h0008, 32'h0, 0});

    repeat (4) idle();
    chk("rd_drain", rq.size(), 32'h0);
    chk("wr_drain", wq.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
